// File: rtl/lc3b_types.sv
// Shared types for the execute-stage indirect-op sequencer.
package lc3b_types;

    typedef enum logic [1:0] {
        KIND_NORM = 2'd0,
        KIND_LDI  = 2'd1,
        KIND_STI  = 2'd2
    } ex_seq_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        PTR_WAIT,
        PTR_ISSUE,
        FINAL
    } ex_seq_state_t;

    // Enough for up to 7 levels of indirection.
    localparam int unsigned EX_SEQ_LVL_W = 3;

endpackage

// File: rtl/ex_out_slot.sv
// Single-entry valid/ready hold register driving the memory-stage request.
module ex_out_slot #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned REG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             push_read,
    input  logic             push_write,
    input  logic [WIDTH-1:0] push_wdata,
    input  logic [REG_W-1:0] push_dr,
    input  logic             push_last,
    input  logic             ready,
    output logic             free,
    output logic             valid,
    output logic [WIDTH-1:0] addr,
    output logic             read,
    output logic             write,
    output logic [WIDTH-1:0] wdata,
    output logic [REG_W-1:0] dr,
    output logic             last
);

    // Loadable when empty or being drained this cycle.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            read  <= 1'b0;
            write <= 1'b0;
            wdata <= '0;
            dr    <= '0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
            read  <= push_read;
            write <= push_write;
            wdata <= push_wdata;
            dr    <= push_dr;
            last  <= push_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_indirect_seq.sv
// Cracks indirect loads/stores into DEPTH pointer reads plus one final access.
// Optional macro EX_IND_PTR_ALIGN_EN: force pointer bit 0 low and flag odd pointers.
module ex_indirect_seq
    import lc3b_types::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned REG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  ex_seq_kind_t     in_kind,
    input  logic             in_rd,
    input  logic             in_wr,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_data,
    input  logic [REG_W-1:0] in_dr,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [REG_W-1:0] mem_dr,
    output logic             mem_last,
    input  logic             rd_valid,
    input  logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             err_misalign
);

    localparam logic [EX_SEQ_LVL_W-1:0] LVL_ONE = EX_SEQ_LVL_W'(1);
    localparam logic [EX_SEQ_LVL_W-1:0] LVL_MAX = EX_SEQ_LVL_W'(DEPTH);

    ex_seq_state_t           state_q, state_d;
    logic [EX_SEQ_LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0]        ptr_q, ptr_d;
    logic [WIDTH-1:0]        sdata_q, sdata_d;
    logic [REG_W-1:0]        dr_q, dr_d;
    logic                    sti_q, sti_d;

    logic             slot_free;
    logic             push;
    logic [WIDTH-1:0] p_addr;
    logic             p_read;
    logic             p_write;
    logic [WIDTH-1:0] p_wdata;
    logic [REG_W-1:0] p_dr;
    logic             p_last;
    logic [WIDTH-1:0] cap_ptr;

`ifdef EX_IND_PTR_ALIGN_EN
    logic err_q;

    assign cap_ptr = {rd_data[WIDTH-1:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= !flush && (state_q == PTR_WAIT) && rd_valid && rd_data[0];
        end
    end

    assign err_misalign = err_q;
`else
    assign cap_ptr      = rd_data;
    assign err_misalign = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) && slot_free && !flush;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        ptr_d   = ptr_q;
        sdata_d = sdata_q;
        dr_d    = dr_q;
        sti_d   = sti_q;
        push    = 1'b0;
        p_addr  = '0;
        p_read  = 1'b0;
        p_write = 1'b0;
        p_wdata = '0;
        p_dr    = dr_q;
        p_last  = 1'b0;

        if (flush) begin
            state_d = IDLE;
            level_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        push   = 1'b1;
                        p_addr = in_addr;
                        p_dr   = in_dr;
                        if (in_kind == KIND_LDI || in_kind == KIND_STI) begin
                            p_read  = 1'b1;
                            sdata_d = in_data;
                            dr_d    = in_dr;
                            sti_d   = (in_kind == KIND_STI);
                            level_d = LVL_ONE;
                            state_d = PTR_WAIT;
                        end else begin
                            p_read  = in_rd;
                            p_write = in_wr;
                            p_wdata = in_data;
                            p_last  = 1'b1;
                        end
                    end
                end
                PTR_WAIT: begin
                    if (rd_valid) begin
                        ptr_d = cap_ptr;
                        if (level_q < LVL_MAX) begin
                            // Issue straight away if the slot can take it.
                            if (slot_free) begin
                                push    = 1'b1;
                                p_addr  = cap_ptr;
                                p_read  = 1'b1;
                                level_d = level_q + LVL_ONE;
                            end else begin
                                state_d = PTR_ISSUE;
                            end
                        end else begin
                            state_d = FINAL;
                        end
                    end
                end
                PTR_ISSUE: begin
                    if (slot_free) begin
                        push    = 1'b1;
                        p_addr  = ptr_q;
                        p_read  = 1'b1;
                        level_d = level_q + LVL_ONE;
                        state_d = PTR_WAIT;
                    end
                end
                FINAL: begin
                    if (slot_free) begin
                        push    = 1'b1;
                        p_addr  = ptr_q;
                        p_read  = !sti_q;
                        p_write = sti_q;
                        p_wdata = sdata_q;
                        p_last  = 1'b1;
                        level_d = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            ptr_q   <= '0;
            sdata_q <= '0;
            dr_q    <= '0;
            sti_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            ptr_q   <= ptr_d;
            sdata_q <= sdata_d;
            dr_q    <= dr_d;
            sti_q   <= sti_d;
        end
    end

    ex_out_slot #(
        .WIDTH (WIDTH),
        .REG_W (REG_W)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .push_addr  (p_addr),
        .push_read  (p_read),
        .push_write (p_write),
        .push_wdata (p_wdata),
        .push_dr    (p_dr),
        .push_last  (p_last),
        .ready      (mem_ready),
        .free       (slot_free),
        .valid      (mem_valid),
        .addr       (mem_addr),
        .read       (mem_read),
        .write      (mem_write),
        .wdata      (mem_wdata),
        .dr         (mem_dr),
        .last       (mem_last)
    );

endmodule

// File: doc/ex_indirect_seq.md
Name: ex_indirect_seq

Overview:
- Parametrised successor to the execute stage's indirect-op handling. Sits between execute and memory.
- Cracks indirect loads and stores into a chain of pointer reads plus one final access, entirely inside the block. Decode-side next-opcode peeking is not used.
- Chain length is set by DEPTH, so a single level gives LC-3b LDI/STI.
- Normal ops pass through a registered valid/ready slot.

Parameters:
- WIDTH, 16, data/address width.
- DEPTH, 1, pointer indirection levels per indirect op (1..7).
- REG_W, 3, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of in-flight op (branch redirect).
- in_valid  in  1  execute presents an op.
- in_ready  out  1  block accepts op this cycle.
- in_kind  in  2  ex_seq_kind_t: KIND_NORM, KIND_LDI, KIND_STI.
- in_rd  in  1  normal op is a memory read.
- in_wr  in  1  normal op is a memory write.
- in_addr  in  WIDTH  effective address from address adder.
- in_data  in  WIDTH  ALU result / store data.
- in_dr  in  REG_W  destination register.
- mem_valid  out  1  memory request/op valid.
- mem_ready  in  1  memory stage accepts.
- mem_addr  out  WIDTH  access address.
- mem_read  out  1  read access.
- mem_write  out  1  write access.
- mem_wdata  out  WIDTH  store data / pass-through result.
- mem_dr  out  REG_W  destination register.
- mem_last  out  1  architectural op (writes back / commits); 0 for pointer reads.
- rd_valid  in  1  pointer read data returned.
- rd_data  in  WIDTH  returned pointer.
- busy  out  1  FSM not IDLE.
- err_misalign  out  1  one-cycle pulse, see optional feature.

Behaviour:
- Reset (rst_n=0, async): state IDLE, level=0, ptr/data regs 0; mem_valid, mem_read, mem_write, mem_last, busy, err_misalign all 0; mem_addr, mem_wdata, mem_dr 0.
- Output slot: mem_* is registered and held stable while mem_valid && !mem_ready. The slot loads when empty or when mem_ready=1 in the same cycle.
- in_ready = (state==IDLE) && (!mem_valid || mem_ready) && !flush.
- KIND_NORM accept:
  - Slot loads next edge: addr=in_addr, read=in_rd, write=in_wr, wdata=in_data, dr=in_dr, last=1.
  - Latency 1 cycle. Back-to-back accepts allowed, giving full throughput.
- KIND_LDI/KIND_STI accept:
  - Latch in_data (store data) and in_dr.
  - Slot loads a pointer read: addr=in_addr, read=1, write=0, last=0.
  - level=1, state PTR_WAIT.
- PTR_WAIT: waits for rd_valid; rd_valid in any other state is ignored. On rd_valid, ptr=rd_data, then:
  - If level<DEPTH: issue the next pointer read at ptr, level+1, stay PTR_WAIT. The read is issued via state PTR_ISSUE if the slot is busy.
  - If level==DEPTH: state FINAL.
- FINAL: when the slot is free, issue one access at ptr with last=1, then return to IDLE.
  - LDI: read=1.
  - STI: write=1, wdata=latched store data.
- A pointer read is never issued before the previous one is accepted (mem_ready).
- Total memory accesses per indirect op = DEPTH+1. Minimum occupancy is DEPTH+1 cycles plus memory latency.
- flush:
  - Next edge: state IDLE, level=0, mem_valid=0, busy=0.
  - Flush wins over a simultaneous rd_valid, in_valid or mem_ready. That rd_data is discarded.
- Address arithmetic: none beyond pass-through. WIDTH-bit values, no wrap logic needed.
- Asynchronous reset mid-chain: same effect as flush, no partial access retained.

Optional Feature:
- Macro EX_IND_PTR_ALIGN_EN.
- Defined:
  - Each captured pointer has bit 0 forced to 0 before use.
  - If rd_data[0]==1, err_misalign pulses 1 for exactly the capture cycle+1.
- Undefined: pointer used unmodified; err_misalign tied 0.

Decomposition:
- lc3b_types gains ex_seq_kind_t (2-bit enum) and ex_seq_state_t (IDLE, PTR_WAIT, PTR_ISSUE, FINAL).
- One sub-module: ex_out_slot, a parametrised WIDTH/REG_W single-entry valid/ready hold register used for the mem_* outputs.

Test Plan:
- Reset/normal: rst_n low mid-cycle → all outputs 0 immediately. Then NORM add, in_data=16'h0042, dr=3 → next cycle mem_valid=1, last=1, wdata=16'h0042, dr=3, read=write=0.
- LDI, DEPTH=1: in_addr=16'h1000; rd_data=16'h2000 two cycles after the read is accepted → second access read at 16'h2000, last=1, dr preserved. Exactly 2 mem accesses. in_ready low throughout.
- STI, DEPTH=2: in_addr=16'h3000, data=16'hBEEF; pointers 16'h3100 then 16'h3200 → reads at 16'h3000, 16'h3100, then write 16'h3200/16'hBEEF with last=1.
- Backpressure: mem_ready=0 for 5 cycles while a pointer read is pending → mem_addr/mem_read stable, no second request, in_ready=0.
- Flush with simultaneous rd_valid in PTR_WAIT → next cycle IDLE, mem_valid=0, no final access. A following NORM op is accepted normally.
- Macro on: rd_data=16'h2001 → final access at 16'h2000, err_misalign single-cycle pulse. Macro off: access at 16'h2001, err_misalign=0.
